id_ex_operand_stage: RTL and testbench

- ID/EX pipeline register for the pipelined MIPS core. Sits directly downstream of register_file.
- Captures busX/busY, immediate and control for the decoded instruction, then presents forwarded operands to the ALU.
- Applies a write-before-read bypass, because the register file write lands on the same edge the read is captured.
- Detects load-use hazards and handles flush and global freeze.

---
 rtl/cpu_pkg.sv | 14 +
 rtl/id_ex_operand_stage_fwd_mux.sv | 32 +++
 rtl/id_ex_operand_stage.sv | 147 ++++++++++++++
 tb/tb_id_ex_operand_stage.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared widths and EX/MEM/WB control bit-field positions for the pipelined MIPS core.
package cpu_pkg;
    localparam int DATA_W = 32;
    localparam int REG_AW = 5;
    localparam int CTRL_W = 8;

    // Bit positions inside the opaque ctrl bundle carried from ID to EX
    localparam int CTRL_ALU_SRC   = 0;
    localparam int CTRL_ALU_OP_LO = 1;
    localparam int CTRL_ALU_OP_HI = 4;
    localparam int CTRL_MEM_WRITE = 5;
    localparam int CTRL_MEM_TO_REG = 6;
    localparam int CTRL_BRANCH    = 7;
endpackage

// File: rtl/id_ex_operand_stage_fwd_mux.sv
// Index compare plus two-source priority select; source a beats source b, index 0 never forwards.
// Purely combinational, no backpressure.
module fwd_mux
    import cpu_pkg::*;
#(
    parameter int DW = cpu_pkg::DATA_W,
    parameter int AW = cpu_pkg::REG_AW
) (
    input  logic [AW-1:0] idx,
    input  logic [DW-1:0] dflt,
    input  logic          a_en,
    input  logic [AW-1:0] a_rd,
    input  logic [DW-1:0] a_dat,
    input  logic          b_en,
    input  logic [AW-1:0] b_rd,
    input  logic [DW-1:0] b_dat,
    output logic [DW-1:0] dat
);
    logic nz;
    logic a_hit;
    logic b_hit;

    assign nz    = (idx != '0);
    assign a_hit = nz && a_en && (a_rd == idx);
    assign b_hit = nz && b_en && (b_rd == idx);

    always_comb begin
        dat = dflt;
        if (a_hit)      dat = a_dat;
        else if (b_hit) dat = b_dat;
    end
endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX register with write-before-read capture bypass, EX forwarding and load-use detection.
// One cycle ID->EX; stall_in freezes all state, hazard_stall holds IF/ID while a bubble is inserted.
module id_ex_operand_stage
    import cpu_pkg::*;
#(
    parameter int DATA_W = cpu_pkg::DATA_W,
    parameter int REG_AW = cpu_pkg::REG_AW,
    parameter int CTRL_W = cpu_pkg::CTRL_W
) (
    input  logic              Clk,
    input  logic              rst_n,
    input  logic              stall_in,
    input  logic              flush,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_uses_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic [DATA_W-1:0] id_busX,
    input  logic [DATA_W-1:0] id_busY,
    input  logic [DATA_W-1:0] id_imm,
    input  logic              id_mem_read,
    input  logic              id_reg_write,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic              exm_reg_write,
    input  logic [REG_AW-1:0] exm_rd,
    input  logic [DATA_W-1:0] exm_result,
    input  logic              mw_reg_write,
    input  logic [REG_AW-1:0] mw_rd,
    input  logic [DATA_W-1:0] mw_result,
    output logic              hazard_stall,
    output logic              ex_valid,
    output logic [REG_AW-1:0] ex_rs,
    output logic [REG_AW-1:0] ex_rt,
    output logic [REG_AW-1:0] ex_rd,
    output logic [DATA_W-1:0] ex_opA,
    output logic [DATA_W-1:0] ex_opB,
    output logic [DATA_W-1:0] ex_imm,
    output logic              ex_mem_read,
    output logic              ex_reg_write,
    output logic [CTRL_W-1:0] ex_ctrl
);
    logic              valid_q, valid_d;
    logic              mem_read_q, mem_read_d;
    logic              reg_write_q, reg_write_d;
    logic [REG_AW-1:0] rs_q, rs_d, rt_q, rt_d, rd_q, rd_d;
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d, imm_q, imm_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [DATA_W-1:0] cap_a, cap_b;

    // The register file writes on the same edge we capture, so WB data must be bypassed in
    fwd_mux #(.DW(DATA_W), .AW(REG_AW)) u_cap_a (
        .idx(id_rs), .dflt(id_busX),
        .a_en(mw_reg_write), .a_rd(mw_rd), .a_dat(mw_result),
        .b_en(1'b0), .b_rd('0), .b_dat('0),
        .dat(cap_a)
    );
    fwd_mux #(.DW(DATA_W), .AW(REG_AW)) u_cap_b (
        .idx(id_rt), .dflt(id_busY),
        .a_en(mw_reg_write), .a_rd(mw_rd), .a_dat(mw_result),
        .b_en(1'b0), .b_rd('0), .b_dat('0),
        .dat(cap_b)
    );
    fwd_mux #(.DW(DATA_W), .AW(REG_AW)) u_ex_a (
        .idx(rs_q), .dflt(a_q),
        .a_en(exm_reg_write), .a_rd(exm_rd), .a_dat(exm_result),
        .b_en(mw_reg_write), .b_rd(mw_rd), .b_dat(mw_result),
        .dat(ex_opA)
    );
    fwd_mux #(.DW(DATA_W), .AW(REG_AW)) u_ex_b (
        .idx(rt_q), .dflt(b_q),
        .a_en(exm_reg_write), .a_rd(exm_rd), .a_dat(exm_result),
        .b_en(mw_reg_write), .b_rd(mw_rd), .b_dat(mw_result),
        .dat(ex_opB)
    );

    always_comb begin
        hazard_stall = !stall_in && id_valid && valid_q && mem_read_q && (rd_q != '0) &&
                       ((rd_q == id_rs) || (id_uses_rt && (rd_q == id_rt)));
    end

    always_comb begin
        valid_d     = valid_q;
        mem_read_d  = mem_read_q;
        reg_write_d = reg_write_q;
        rs_d        = rs_q;
        rt_d        = rt_q;
        rd_d        = rd_q;
        a_d         = a_q;
        b_d         = b_q;
        imm_d       = imm_q;
        ctrl_d      = ctrl_q;
        if (stall_in) begin
            // frozen: flush is expected to stay asserted until the freeze lifts
        end else if (flush || hazard_stall) begin
            valid_d     = 1'b0;
            mem_read_d  = 1'b0;
            reg_write_d = 1'b0;
        end else begin
            valid_d     = id_valid;
            mem_read_d  = id_valid && id_mem_read;
            reg_write_d = id_valid && id_reg_write;
            rs_d        = id_rs;
            rt_d        = id_rt;
            rd_d        = id_rd;
            a_d         = cap_a;
            b_d         = cap_b;
            imm_d       = id_imm;
            ctrl_d      = id_ctrl;
        end
    end

    always_ff @(posedge Clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q     <= 1'b0;
            mem_read_q  <= 1'b0;
            reg_write_q <= 1'b0;
            rs_q        <= '0;
            rt_q        <= '0;
            rd_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            imm_q       <= '0;
            ctrl_q      <= '0;
        end else begin
            valid_q     <= valid_d;
            mem_read_q  <= mem_read_d;
            reg_write_q <= reg_write_d;
            rs_q        <= rs_d;
            rt_q        <= rt_d;
            rd_q        <= rd_d;
            a_q         <= a_d;
            b_q         <= b_d;
            imm_q       <= imm_d;
            ctrl_q      <= ctrl_d;
        end
    end

    assign ex_valid     = valid_q;
    assign ex_mem_read  = mem_read_q;
    assign ex_reg_write = reg_write_q;
    assign ex_rs        = rs_q;
    assign ex_rt        = rt_q;
    assign ex_rd        = rd_q;
    assign ex_imm       = imm_q;
    assign ex_ctrl      = ctrl_q;
endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Randomised plus directed bench for id_ex_operand_stage against an instruction-level model.
module tb_id_ex_operand_stage;
    logic        Clk = 1'b0;
    logic        rst_n, stall_in, flush, id_valid, id_uses_rt, id_mem_read, id_reg_write;
    logic [4:0]  id_rs, id_rt, id_rd, exm_rd, mw_rd;
    logic [31:0] id_busX, id_busY, id_imm, exm_result, mw_result;
    logic [7:0]  id_ctrl;
    logic        exm_reg_write, mw_reg_write;
    logic        hazard_stall, ex_valid, ex_mem_read, ex_reg_write;
    logic [4:0]  ex_rs, ex_rt, ex_rd;
    logic [31:0] ex_opA, ex_opB, ex_imm;
    logic [7:0]  ex_ctrl;

    int n_cmp = 0;
    int n_bad = 0;

    // Model of the instruction sitting in EX
    logic        m_vld, m_mr, m_rw;
    logic [4:0]  m_rs, m_rt, m_rd;
    logic [31:0] m_a, m_b, m_imm;
    logic [7:0]  m_ctrl;

    always #5 Clk = ~Clk;

    id_ex_operand_stage dut (
        .Clk(Clk), .rst_n(rst_n), .stall_in(stall_in), .flush(flush),
        .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .id_rd(id_rd), .id_busX(id_busX), .id_busY(id_busY), .id_imm(id_imm),
        .id_mem_read(id_mem_read), .id_reg_write(id_reg_write), .id_ctrl(id_ctrl),
        .exm_reg_write(exm_reg_write), .exm_rd(exm_rd), .exm_result(exm_result),
        .mw_reg_write(mw_reg_write), .mw_rd(mw_rd), .mw_result(mw_result),
        .hazard_stall(hazard_stall), .ex_valid(ex_valid), .ex_rs(ex_rs), .ex_rt(ex_rt),
        .ex_rd(ex_rd), .ex_opA(ex_opA), .ex_opB(ex_opB), .ex_imm(ex_imm),
        .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write), .ex_ctrl(ex_ctrl)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Value the register file holds for idx as seen by a reader in EX
    function automatic logic [31:0] ex_value(input logic [4:0] idx, input logic [31:0] stored);
        if (idx == 5'd0) return stored;
        if (exm_reg_write && exm_rd == idx) return exm_result;
        if (mw_reg_write && mw_rd == idx) return mw_result;
        return stored;
    endfunction

    function automatic logic [31:0] id_value(input logic [4:0] idx, input logic [31:0] bus);
        if (mw_reg_write && mw_rd != 5'd0 && mw_rd == idx) return mw_result;
        return bus;
    endfunction

    function automatic logic model_hazard();
        if (stall_in || !id_valid || !m_vld || !m_mr || m_rd == 5'd0) return 1'b0;
        return (m_rd == id_rs) || (id_uses_rt && m_rd == id_rt);
    endfunction

    task automatic model_reset();
        m_vld = 0; m_mr = 0; m_rw = 0; m_rs = 0; m_rt = 0; m_rd = 0;
        m_a = 0; m_b = 0; m_imm = 0; m_ctrl = 0;
    endtask

    task automatic idle();
        stall_in = 0; flush = 0; id_valid = 0; id_uses_rt = 0; id_mem_read = 0;
        id_reg_write = 0; id_rs = 0; id_rt = 0; id_rd = 0; id_busX = 0; id_busY = 0;
        id_imm = 0; id_ctrl = 0; exm_reg_write = 0; exm_rd = 0; exm_result = 0;
        mw_reg_write = 0; mw_rd = 0; mw_result = 0;
    endtask

    // Check current cycle against the model, then advance one clock
    task automatic step();
        logic hz, n_vld, n_mr, n_rw;
        logic [31:0] ca, cb;
        #1;
        hz = model_hazard();
        chk("hazard_stall", {31'd0, hazard_stall}, {31'd0, hz});
        chk("ex_valid", {31'd0, ex_valid}, {31'd0, m_vld});
        chk("ex_mem_read", {31'd0, ex_mem_read}, {31'd0, m_mr});
        chk("ex_reg_write", {31'd0, ex_reg_write}, {31'd0, m_rw});
        if (m_vld) begin
            chk("ex_rs", {27'd0, ex_rs}, {27'd0, m_rs});
            chk("ex_rt", {27'd0, ex_rt}, {27'd0, m_rt});
            chk("ex_rd", {27'd0, ex_rd}, {27'd0, m_rd});
            chk("ex_imm", ex_imm, m_imm);
            chk("ex_ctrl", {24'd0, ex_ctrl}, {24'd0, m_ctrl});
            chk("ex_opA", ex_opA, ex_value(m_rs, m_a));
            chk("ex_opB", ex_opB, ex_value(m_rt, m_b));
        end
        n_vld = id_valid; n_mr = id_valid && id_mem_read; n_rw = id_valid && id_reg_write;
        ca = id_value(id_rs, id_busX);
        cb = id_value(id_rt, id_busY);
        @(posedge Clk);
        if (!stall_in) begin
            if (flush || hz) begin
                m_vld = 0; m_mr = 0; m_rw = 0;
            end else begin
                m_vld = n_vld; m_mr = n_mr; m_rw = n_rw;
                m_rs = id_rs; m_rt = id_rt; m_rd = id_rd;
                m_a = ca; m_b = cb; m_imm = id_imm; m_ctrl = id_ctrl;
            end
        end
        @(negedge Clk);
    endtask

    initial begin
        idle();
        model_reset();
        rst_n = 0;
        repeat (2) @(negedge Clk);
        #1;
        chk("rst_valid", {31'd0, ex_valid}, 32'd0);
        chk("rst_hazard", {31'd0, hazard_stall}, 32'd0);
        chk("rst_opA", ex_opA, 32'd0);
        chk("rst_rd", {27'd0, ex_rd}, 32'd0);
        rst_n = 1;
        @(negedge Clk);

        // capture bypass from MEM/WB
        id_valid = 1; id_rs = 3; id_busX = 32'h11; mw_reg_write = 1; mw_rd = 3; mw_result = 32'h55;
        step();
        idle(); #1;
        chk("bypass_opA", ex_opA, 32'h55);
        step();

        // EX/MEM forwarding and priority over MEM/WB
        id_valid = 1; id_rd = 5; id_reg_write = 1;
        step();
        idle(); id_valid = 1; id_rs = 5; id_busX = 32'h22;
        step();
        idle(); exm_reg_write = 1; exm_rd = 5; exm_result = 32'hAB; #1;
        chk("exm_fwd", ex_opA, 32'hAB);
        mw_reg_write = 1; mw_rd = 5; mw_result = 32'hCD; #1;
        chk("exm_prio", ex_opA, 32'hAB);
        exm_reg_write = 0; #1;
        chk("mw_fwd", ex_opA, 32'hCD);
        step();

        // load-use: one bubble, then operand via MEM/WB
        idle(); id_valid = 1; id_mem_read = 1; id_reg_write = 1; id_rd = 8;
        step();
        idle(); id_valid = 1; id_rt = 8; id_uses_rt = 1; id_rd = 9; id_reg_write = 1; id_busY = 32'h777; #1;
        chk("lu_hazard", {31'd0, hazard_stall}, 32'd1);
        step();
        chk("lu_bubble", {31'd0, ex_valid}, 32'd0);
        chk("lu_released", {31'd0, hazard_stall}, 32'd0);
        step();
        idle(); mw_reg_write = 1; mw_rd = 8; mw_result = 32'h1234; #1;
        chk("lu_opB", ex_opB, 32'h1234);
        step();

        // r0 is never forwarded and never stalls
        idle(); id_valid = 1; mw_reg_write = 1; mw_rd = 0; mw_result = 32'hFFFF;
        step();
        idle(); exm_reg_write = 1; exm_rd = 0; exm_result = 32'hFFFF;
        mw_reg_write = 1; mw_rd = 0; mw_result = 32'hFFFF; #1;
        chk("r0_opA", ex_opA, 32'd0);
        step();
        idle(); id_valid = 1; id_mem_read = 1; id_reg_write = 1; id_rd = 0;
        step();
        idle(); id_valid = 1; id_rs = 0; id_rt = 0; id_uses_rt = 1; #1;
        chk("r0_nostall", {31'd0, hazard_stall}, 32'd0);
        step();

        // flush, flush under freeze, 3-cycle freeze
        idle(); id_valid = 1; id_reg_write = 1; id_rd = 4; flush = 1;
        step();
        chk("flush_valid", {31'd0, ex_valid}, 32'd0);
        chk("flush_rw", {31'd0, ex_reg_write}, 32'd0);
        idle(); id_valid = 1; id_reg_write = 1; id_rd = 9; id_imm = 32'h9999;
        step();
        idle(); id_valid = 1; id_rd = 12; flush = 1; stall_in = 1;
        step();
        chk("flushstall_valid", {31'd0, ex_valid}, 32'd1);
        chk("flushstall_rd", {27'd0, ex_rd}, 32'd9);
        for (int i = 0; i < 3; i++) begin
            idle(); stall_in = 1; id_valid = 1; id_rd = 5'($urandom_range(1, 31));
            id_imm = $urandom;
            step();
            chk("stall_rd", {27'd0, ex_rd}, 32'd9);
            chk("stall_imm", ex_imm, 32'h9999);
            chk("stall_valid", {31'd0, ex_valid}, 32'd1);
        end

        // asynchronous reset mid-stream
        idle(); #2;
        rst_n = 0; #1;
        chk("arst_valid", {31'd0, ex_valid}, 32'd0);
        chk("arst_rw", {31'd0, ex_reg_write}, 32'd0);
        chk("arst_imm", ex_imm, 32'd0);
        chk("arst_hazard", {31'd0, hazard_stall}, 32'd0);
        model_reset();
        #1 rst_n = 1;
        @(negedge Clk);

        // random traffic over a small register window to provoke collisions
        for (int c = 0; c < 600; c++) begin
            stall_in      = ($urandom_range(0, 9) == 0);
            flush         = ($urandom_range(0, 9) == 0);
            id_valid      = ($urandom_range(0, 9) < 8);
            id_rs         = 5'($urandom_range(0, 7));
            id_rt         = 5'($urandom_range(0, 7));
            id_rd         = 5'($urandom_range(0, 7));
            id_uses_rt    = 1'($urandom);
            id_busX       = $urandom;
            id_busY       = $urandom;
            id_imm        = $urandom;
            id_mem_read   = ($urandom_range(0, 9) < 3);
            id_reg_write  = 1'($urandom);
            id_ctrl       = 8'($urandom);
            exm_reg_write = 1'($urandom);
            exm_rd        = 5'($urandom_range(0, 7));
            exm_result    = $urandom;
            mw_reg_write  = 1'($urandom);
            mw_rd         = 5'($urandom_range(0, 7));
            mw_result     = $urandom;
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
